control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_if.sv | 56 +++++
 rtl/control_unit.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_if
//  Description : Bundle between the basic-computer control unit and its
//                datapath. The datapath supplies IR, AC, DR and E; the
//                control unit returns load/increment/clear strobes, bus
//                source selects, memory strobes, ALU opcode and status.
//                  master : control unit side (drives strobes and status)
//                  slave  : datapath side (drives IR/AC/DR/E)
//  Revision    : 1.0  initial release
// ============================================================================
interface control_unit_if;
    // datapath -> control
    logic [15:0] IR;
    logic [15:0] AC;
    logic [15:0] DR;
    logic        E;

    // register load strobes
    logic        write_ar, write_pc, write_dr, write_tr, write_ir, write_ac;
    // register increment strobes
    logic        increment_ar, increment_pc, increment_dr, increment_tr, increment_ac;
    // synchronous register clear strobes
    logic        reset_ar, reset_pc, reset_dr, reset_tr, reset_ac;
    // bus source selects
    logic        read_ar, read_pc, read_dr, read_tr, read_ir, read_ac;
    // memory
    logic        memory_read, memory_write;
    // ALU / flags / status
    logic [2:0]  alu_op;
    logic        write_e;
    logic        IEN;
    logic        halted;
    logic [2:0]  sc;

    modport master (
        input  IR, AC, DR, E,
        output write_ar, write_pc, write_dr, write_tr, write_ir, write_ac,
        output increment_ar, increment_pc, increment_dr, increment_tr, increment_ac,
        output reset_ar, reset_pc, reset_dr, reset_tr, reset_ac,
        output read_ar, read_pc, read_dr, read_tr, read_ir, read_ac,
        output memory_read, memory_write,
        output alu_op, write_e, IEN, halted, sc
    );

    modport slave (
        output IR, AC, DR, E,
        input  write_ar, write_pc, write_dr, write_tr, write_ir, write_ac,
        input  increment_ar, increment_pc, increment_dr, increment_tr, increment_ac,
        input  reset_ar, reset_pc, reset_dr, reset_tr, reset_ac,
        input  read_ar, read_pc, read_dr, read_tr, read_ir, read_ac,
        input  memory_read, memory_write,
        input  alu_op, write_e, IEN, halted, sc
    );
endinterface
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Hardwired control unit of the basic 16-bit computer.
//                A sequence counter (T0..T6) steps through fetch, decode,
//                indirect-address and execute phases; all strobes are
//                decoded combinationally from sc, IR, halted, AC, DR, E.
//  Ports       : clk   - single clock, rising edge
//                reset - asynchronous active-high reset
//                bus   - control_unit_if.master (IR/AC/DR/E in, strobes,
//                        alu_op, write_e, IEN, halted, sc out)
//  Revision    : 1.0  initial release
// ============================================================================
module control_unit #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    control_unit_if.master        bus
);

    // sequence-counter states
    localparam logic [2:0] c_T0 = 3'd0;
    localparam logic [2:0] c_T1 = 3'd1;
    localparam logic [2:0] c_T2 = 3'd2;
    localparam logic [2:0] c_T3 = 3'd3;
    localparam logic [2:0] c_T4 = 3'd4;
    localparam logic [2:0] c_T5 = 3'd5;
    localparam logic [2:0] c_T6 = 3'd6;

    // opcode field D
    localparam logic [2:0] c_OP_AND = 3'd0;
    localparam logic [2:0] c_OP_ADD = 3'd1;
    localparam logic [2:0] c_OP_LDA = 3'd2;
    localparam logic [2:0] c_OP_STA = 3'd3;
    localparam logic [2:0] c_OP_BUN = 3'd4;
    localparam logic [2:0] c_OP_BSA = 3'd5;
    localparam logic [2:0] c_OP_ISZ = 3'd6;
    localparam logic [2:0] c_OP_REG = 3'd7;

    // ALU operation codes
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_ADD = 3'b001;
    localparam logic [2:0] c_ALU_DR  = 3'b010;
    localparam logic [2:0] c_ALU_CMA = 3'b011;
    localparam logic [2:0] c_ALU_CIR = 3'b100;
    localparam logic [2:0] c_ALU_CIL = 3'b101;
    localparam logic [2:0] c_ALU_CLE = 3'b110;
    localparam logic [2:0] c_ALU_CME = 3'b111;

    // register-reference one-hot codes (after highest-bit isolation)
    localparam logic [ADDR_WIDTH-1:0] c_RR_CLA = 12'h800;
    localparam logic [ADDR_WIDTH-1:0] c_RR_CLE = 12'h400;
    localparam logic [ADDR_WIDTH-1:0] c_RR_CMA = 12'h200;
    localparam logic [ADDR_WIDTH-1:0] c_RR_CME = 12'h100;
    localparam logic [ADDR_WIDTH-1:0] c_RR_CIR = 12'h080;
    localparam logic [ADDR_WIDTH-1:0] c_RR_CIL = 12'h040;
    localparam logic [ADDR_WIDTH-1:0] c_RR_INC = 12'h020;
    localparam logic [ADDR_WIDTH-1:0] c_RR_SPA = 12'h010;
    localparam logic [ADDR_WIDTH-1:0] c_RR_SNA = 12'h008;
    localparam logic [ADDR_WIDTH-1:0] c_RR_SZA = 12'h004;
    localparam logic [ADDR_WIDTH-1:0] c_RR_SZE = 12'h002;
    localparam logic [ADDR_WIDTH-1:0] c_RR_HLT = 12'h001;

    // I/O codes (exact match)
    localparam logic [ADDR_WIDTH-1:0] c_IO_ION = 12'h080;
    localparam logic [ADDR_WIDTH-1:0] c_IO_IOF = 12'h040;

    logic [2:0]            r_sc_q;
    logic [2:0]            w_sc_d;
    logic                  r_halted_q;
    logic                  w_halted_d;
    logic                  r_ien_q;
    logic                  w_ien_d;

    logic [2:0]            w_d;
    logic                  w_i;
    logic [ADDR_WIDTH-1:0] w_rr_sel;
    logic                  w_last;
    logic                  w_set_halt;
    logic                  w_set_ien;
    logic                  w_clr_ien;

    assign w_d = bus.IR[14:12];
    assign w_i = bus.IR[15];

    // Keep only the most significant set bit of the address field so that
    // register-reference words with several bits set execute one operation.
    always_comb begin
        w_rr_sel = '0;
        for (int k = 0; k < ADDR_WIDTH; k++) begin
            if (bus.IR[k]) begin
                w_rr_sel    = '0;
                w_rr_sel[k] = 1'b1;
            end
        end
    end

    always_comb begin
        bus.write_ar     = 1'b0;
        bus.write_pc     = 1'b0;
        bus.write_dr     = 1'b0;
        bus.write_tr     = 1'b0;
        bus.write_ir     = 1'b0;
        bus.write_ac     = 1'b0;
        bus.increment_ar = 1'b0;
        bus.increment_pc = 1'b0;
        bus.increment_dr = 1'b0;
        bus.increment_tr = 1'b0;
        bus.increment_ac = 1'b0;
        bus.reset_ar     = 1'b0;
        bus.reset_pc     = 1'b0;
        bus.reset_dr     = 1'b0;
        bus.reset_tr     = 1'b0;
        bus.reset_ac     = 1'b0;
        bus.read_ar      = 1'b0;
        bus.read_pc      = 1'b0;
        bus.read_dr      = 1'b0;
        bus.read_tr      = 1'b0;
        bus.read_ir      = 1'b0;
        bus.read_ac      = 1'b0;
        bus.memory_read  = 1'b0;
        bus.memory_write = 1'b0;
        bus.alu_op       = c_ALU_AND;
        bus.write_e      = 1'b0;
        w_last           = 1'b0;
        w_set_halt       = 1'b0;
        w_set_ien        = 1'b0;
        w_clr_ien        = 1'b0;

        if (reset) begin
            // hold every datapath register cleared while reset is applied
            bus.reset_ar = 1'b1;
            bus.reset_pc = 1'b1;
            bus.reset_dr = 1'b1;
            bus.reset_tr = 1'b1;
            bus.reset_ac = 1'b1;
        end else if (!r_halted_q) begin
            case (r_sc_q)
                c_T0: begin
                    bus.read_pc  = 1'b1;
                    bus.write_ar = 1'b1;
                end
                c_T1: begin
                    bus.memory_read  = 1'b1;
                    bus.write_ir     = 1'b1;
                    bus.increment_pc = 1'b1;
                end
                c_T2: begin
                    bus.read_ir  = 1'b1;
                    bus.write_ar = 1'b1;
                end
                c_T3: begin
                    if (w_d != c_OP_REG) begin
                        if (w_i) begin
                            bus.memory_read = 1'b1;
                            bus.write_ar    = 1'b1;
                        end
                    end else if (!w_i) begin
                        w_last = 1'b1;
                        case (w_rr_sel)
                            c_RR_CLA: bus.reset_ac = 1'b1;
                            c_RR_CLE: begin
                                bus.alu_op  = c_ALU_CLE;
                                bus.write_e = 1'b1;
                            end
                            c_RR_CMA: begin
                                bus.alu_op   = c_ALU_CMA;
                                bus.write_ac = 1'b1;
                            end
                            c_RR_CME: begin
                                bus.alu_op  = c_ALU_CME;
                                bus.write_e = 1'b1;
                            end
                            c_RR_CIR: begin
                                bus.alu_op   = c_ALU_CIR;
                                bus.write_ac = 1'b1;
                                bus.write_e  = 1'b1;
                            end
                            c_RR_CIL: begin
                                bus.alu_op   = c_ALU_CIL;
                                bus.write_ac = 1'b1;
                                bus.write_e  = 1'b1;
                            end
                            c_RR_INC: bus.increment_ac = 1'b1;
                            c_RR_SPA: bus.increment_pc = ~bus.AC[15];
                            c_RR_SNA: bus.increment_pc = bus.AC[15];
                            c_RR_SZA: bus.increment_pc = (bus.AC == 16'h0000);
                            c_RR_SZE: bus.increment_pc = ~bus.E;
                            c_RR_HLT: w_set_halt = 1'b1;
                            default:  ;
                        endcase
                    end else begin
                        w_last = 1'b1;
                        if (bus.IR[ADDR_WIDTH-1:0] == c_IO_ION) w_set_ien = 1'b1;
                        if (bus.IR[ADDR_WIDTH-1:0] == c_IO_IOF) w_clr_ien = 1'b1;
                    end
                end
                c_T4: begin
                    case (w_d)
                        c_OP_AND, c_OP_ADD, c_OP_LDA, c_OP_ISZ: begin
                            bus.memory_read = 1'b1;
                            bus.write_dr    = 1'b1;
                        end
                        c_OP_STA: begin
                            bus.read_ac      = 1'b1;
                            bus.memory_write = 1'b1;
                            w_last           = 1'b1;
                        end
                        c_OP_BUN: begin
                            bus.read_ar  = 1'b1;
                            bus.write_pc = 1'b1;
                            w_last       = 1'b1;
                        end
                        c_OP_BSA: begin
                            bus.read_pc      = 1'b1;
                            bus.memory_write = 1'b1;
                            bus.increment_ar = 1'b1;
                        end
                        // only reachable if IR changed mid-instruction
                        default: w_last = 1'b1;
                    endcase
                end
                c_T5: begin
                    w_last = 1'b1;
                    case (w_d)
                        c_OP_AND: begin
                            bus.write_ac = 1'b1;
                            bus.alu_op   = c_ALU_AND;
                        end
                        c_OP_ADD: begin
                            bus.write_ac = 1'b1;
                            bus.write_e  = 1'b1;
                            bus.alu_op   = c_ALU_ADD;
                        end
                        c_OP_LDA: begin
                            bus.write_ac = 1'b1;
                            bus.alu_op   = c_ALU_DR;
                        end
                        c_OP_BSA: begin
                            bus.read_ar  = 1'b1;
                            bus.write_pc = 1'b1;
                        end
                        c_OP_ISZ: begin
                            bus.increment_dr = 1'b1;
                            w_last           = 1'b0;
                        end
                        default: ;
                    endcase
                end
                c_T6: begin
                    // T6 always ends the instruction so sc cannot pass 6
                    w_last = 1'b1;
                    if (w_d == c_OP_ISZ) begin
                        bus.read_dr      = 1'b1;
                        bus.memory_write = 1'b1;
                        bus.increment_pc = (bus.DR == 16'h0000);
                    end
                end
                default: w_last = 1'b1;
            endcase
        end
    end

    always_comb begin
        if (r_halted_q || w_last) begin
            w_sc_d = c_T0;
        end else begin
            w_sc_d = r_sc_q + 3'd1;
        end
        w_halted_d = r_halted_q | w_set_halt;
        if (w_set_ien) begin
            w_ien_d = 1'b1;
        end else if (w_clr_ien) begin
            w_ien_d = 1'b0;
        end else begin
            w_ien_d = r_ien_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sc_q     <= c_T0;
            r_halted_q <= 1'b0;
            r_ien_q    <= 1'b0;
        end else begin
            r_sc_q     <= w_sc_d;
            r_halted_q <= w_halted_d;
            r_ien_q    <= w_ien_d;
        end
    end

    assign bus.sc     = r_sc_q;
    assign bus.halted = r_halted_q;
    assign bus.IEN    = r_ien_q;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit
//  Description : Self-checking bench for control_unit. A driver issues whole
//                instructions; a reference model expands each instruction
//                into its micro-operation list and queues one expectation
//                per cycle. A monitor on the falling edge pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_control_unit;

    logic clk = 1'b0;
    logic reset;

    control_unit_if bus ();

    control_unit #(.ADDR_WIDTH(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // strobe bit positions in the packed observation word
    localparam logic [24:0] M_WAR  = 25'd1 << 0;
    localparam logic [24:0] M_WPC  = 25'd1 << 1;
    localparam logic [24:0] M_WDR  = 25'd1 << 2;
    localparam logic [24:0] M_WIR  = 25'd1 << 4;
    localparam logic [24:0] M_WAC  = 25'd1 << 5;
    localparam logic [24:0] M_IAR  = 25'd1 << 6;
    localparam logic [24:0] M_IPC  = 25'd1 << 7;
    localparam logic [24:0] M_IDR  = 25'd1 << 8;
    localparam logic [24:0] M_IAC  = 25'd1 << 10;
    localparam logic [24:0] M_RSAC = 25'd1 << 15;
    localparam logic [24:0] M_RST  = 25'h00F800;
    localparam logic [24:0] M_RAR  = 25'd1 << 16;
    localparam logic [24:0] M_RPC  = 25'd1 << 17;
    localparam logic [24:0] M_RDR  = 25'd1 << 18;
    localparam logic [24:0] M_RIR  = 25'd1 << 20;
    localparam logic [24:0] M_RAC  = 25'd1 << 21;
    localparam logic [24:0] M_MR   = 25'd1 << 22;
    localparam logic [24:0] M_MW   = 25'd1 << 23;
    localparam logic [24:0] M_WE   = 25'd1 << 24;

    logic [24:0] act;
    assign act = {bus.write_e, bus.memory_write, bus.memory_read,
                  bus.read_ac, bus.read_ir, bus.read_tr, bus.read_dr, bus.read_pc, bus.read_ar,
                  bus.reset_ac, bus.reset_tr, bus.reset_dr, bus.reset_pc, bus.reset_ar,
                  bus.increment_ac, bus.increment_tr, bus.increment_dr, bus.increment_pc, bus.increment_ar,
                  bus.write_ac, bus.write_ir, bus.write_tr, bus.write_dr, bus.write_pc, bus.write_ar};

    typedef struct {
        logic [24:0] mask;
        logic [2:0]  alu;
        logic [2:0]  sc;
        logic        ien;
        logic        halted;
        logic [15:0] ir;
        int          step;
    } exp_t;

    typedef struct {
        logic [24:0] mask;
        logic [2:0]  alu;
    } uop_t;

    exp_t sb_q[$];
    uop_t plan[$];

    int   n_checks = 0;
    int   n_errors = 0;
    bit   armed    = 1'b0;
    bit   sb_en    = 1'b1;
    logic m_ien    = 1'b0;
    logic m_halted = 1'b0;
    bit   eff_halt;
    int   eff_ien;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        int   nsrc;
        nsrc = $countones({bus.read_ar, bus.read_pc, bus.read_dr, bus.read_tr,
                           bus.read_ir, bus.read_ac, bus.memory_read});
        n_checks++;
        if (nsrc > 1) begin
            n_errors++;
            $display("FAIL bus_exclusive t=%0t: %0d sources high, at most 1 allowed", $time, nsrc);
        end
        n_checks++;
        if (bus.sc > 3'd6) begin
            n_errors++;
            $display("FAIL sc_range t=%0t: sc=%0d, must be <= 6", $time, bus.sc);
        end
        if (sb_en && armed) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard_empty t=%0t: no expectation queued", $time);
            end else begin
                e = sb_q.pop_front();
                n_checks++;
                if (act !== e.mask || bus.alu_op !== e.alu) begin
                    n_errors++;
                    $display("FAIL strobes ir=%h step=%0d: got strobes=%h alu=%b, expected strobes=%h alu=%b",
                             e.ir, e.step, act, bus.alu_op, e.mask, e.alu);
                end
                n_checks++;
                if ({bus.sc, bus.IEN, bus.halted} !== {e.sc, e.ien, e.halted}) begin
                    n_errors++;
                    $display("FAIL state ir=%h step=%0d: got sc=%0d IEN=%b halted=%b, expected sc=%0d IEN=%b halted=%b",
                             e.ir, e.step, bus.sc, bus.IEN, bus.halted, e.sc, e.ien, e.halted);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic add_uop(input logic [24:0] m, input logic [2:0] a);
        uop_t u;
        u.mask = m;
        u.alu  = a;
        plan.push_back(u);
    endtask

    // Expand one instruction into its per-cycle micro-operations.
    task automatic build_plan(input logic [15:0] ir, input logic [15:0] ac,
                              input logic [15:0] dr, input logic e);
        int d;
        int hb;
        plan.delete();
        eff_halt = 1'b0;
        eff_ien  = -1;
        d = int'(ir[14:12]);
        add_uop(M_RPC | M_WAR, 3'd0);
        add_uop(M_MR | M_WIR | M_IPC, 3'd0);
        add_uop(M_RIR | M_WAR, 3'd0);
        if (d != 7) begin
            add_uop(ir[15] ? (M_MR | M_WAR) : 25'd0, 3'd0);
            case (d)
                0, 1, 2: begin
                    add_uop(M_MR | M_WDR, 3'd0);
                    add_uop(M_WAC | ((d == 1) ? M_WE : 25'd0), 3'(d));
                end
                3: add_uop(M_RAC | M_MW, 3'd0);
                4: add_uop(M_RAR | M_WPC, 3'd0);
                5: begin
                    add_uop(M_RPC | M_MW | M_IAR, 3'd0);
                    add_uop(M_RAR | M_WPC, 3'd0);
                end
                default: begin
                    add_uop(M_MR | M_WDR, 3'd0);
                    add_uop(M_IDR, 3'd0);
                    add_uop(M_RDR | M_MW | ((dr == 16'd0) ? M_IPC : 25'd0), 3'd0);
                end
            endcase
        end else if (!ir[15]) begin
            hb = -1;
            for (int k = 0; k < 12; k++) if (ir[k]) hb = k;
            case (hb)
                11: add_uop(M_RSAC, 3'd0);
                10: add_uop(M_WE, 3'd6);
                9:  add_uop(M_WAC, 3'd3);
                8:  add_uop(M_WE, 3'd7);
                7:  add_uop(M_WAC | M_WE, 3'd4);
                6:  add_uop(M_WAC | M_WE, 3'd5);
                5:  add_uop(M_IAC, 3'd0);
                4:  add_uop(ac[15] ? 25'd0 : M_IPC, 3'd0);
                3:  add_uop(ac[15] ? M_IPC : 25'd0, 3'd0);
                2:  add_uop((ac == 16'd0) ? M_IPC : 25'd0, 3'd0);
                1:  add_uop(e ? 25'd0 : M_IPC, 3'd0);
                0: begin
                    add_uop(25'd0, 3'd0);
                    eff_halt = 1'b1;
                end
                default: add_uop(25'd0, 3'd0);
            endcase
        end else begin
            if (ir[11:0] == 12'h080) eff_ien = 1;
            if (ir[11:0] == 12'h040) eff_ien = 0;
            add_uop(25'd0, 3'd0);
        end
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [24:0] m, input logic [2:0] a, input logic [2:0] s, input int step);
        exp_t e;
        e.mask   = m;
        e.alu    = a;
        e.sc     = s;
        e.ien    = m_ien;
        e.halted = m_halted;
        e.ir     = bus.IR;
        e.step   = step;
        sb_q.push_back(e);
        armed = 1'b1;
    endtask

    task automatic do_reset(input int n);
        sb_en    = 1'b1;
        reset    = 1'b1;
        m_ien    = 1'b0;
        m_halted = 1'b0;
        repeat (n) begin
            push_exp(M_RST, 3'd0, 3'd0, -1);
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic run_steps(input logic [15:0] ir, input logic [15:0] ac, input logic [15:0] dr,
                             input logic e, input int nmax);
        bus.IR = ir;
        bus.AC = ac;
        bus.DR = dr;
        bus.E  = e;
        build_plan(ir, ac, dr, e);
        for (int k = 0; k < plan.size() && k < nmax; k++) begin
            push_exp(plan[k].mask, plan[k].alu, 3'(k), k);
            tick();
        end
    endtask

    task automatic run_instr(input logic [15:0] ir, input logic [15:0] ac, input logic [15:0] dr, input logic e);
        run_steps(ir, ac, dr, e, 99);
        if (eff_halt) m_halted = 1'b1;
        if (eff_ien >= 0) m_ien = eff_ien[0];
    endtask

    task automatic run_halted(input int n);
        repeat (n) begin
            bus.IR = 16'($urandom);
            push_exp(25'd0, 3'd0, 3'd0, -2);
            tick();
        end
    endtask

    initial begin
        logic [15:0] ir;
        logic [15:0] ac;
        logic [15:0] dr;
        reset  = 1'b1;
        bus.IR = 16'h0000;
        bus.AC = 16'h0000;
        bus.DR = 16'h0000;
        bus.E  = 1'b0;
        @(posedge clk);
        #1;
        do_reset(3);

        run_instr(16'h1234, 16'h0F0F, 16'h1111, 1'b0);   // ADD direct
        run_instr(16'hD005, 16'h0000, 16'h0000, 1'b0);   // BSA indirect
        run_instr(16'h6010, 16'h0000, 16'h0000, 1'b0);   // ISZ, DR==0 skips
        run_instr(16'h6010, 16'h0000, 16'h0001, 1'b0);   // ISZ, DR!=0
        run_instr(16'hE005, 16'h0000, 16'h0000, 1'b1);   // ISZ indirect
        run_instr(16'h7004, 16'h0000, 16'h0000, 1'b0);   // SZA, AC==0
        run_instr(16'h7004, 16'h0005, 16'h0000, 1'b0);   // SZA, AC!=0
        run_instr(16'h7A00, 16'h1234, 16'h0000, 1'b0);   // several bits: CLA wins
        run_instr(16'h7003, 16'h1234, 16'h0000, 1'b0);   // SZE wins over HLT bit
        run_instr(16'h3000, 16'h1234, 16'h0000, 1'b0);   // STA
        run_instr(16'hC123, 16'h1234, 16'h0000, 1'b0);   // BUN indirect
        run_instr(16'hF080, 16'h0000, 16'h0000, 1'b0);   // ION
        run_instr(16'hF040, 16'h0000, 16'h0000, 1'b0);   // IOF
        run_instr(16'hF080, 16'h0000, 16'h0000, 1'b0);   // ION again
        run_steps(16'h1234, 16'h0000, 16'h0000, 1'b0, 4); // abort at T4 by reset
        do_reset(2);
        run_instr(16'h7001, 16'h0000, 16'h0000, 1'b0);   // HLT
        run_halted(10);
        do_reset(2);

        for (int n = 0; n < 150; n++) begin
            ir = 16'($urandom);
            if (ir[14:12] == 3'd7 && !ir[15] && ir[11:0] == 12'h001) ir[11:0] = 12'h002;
            ac = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            dr = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
            run_instr(ir, ac, dr, 1'($urandom));
        end

        // IR changing every cycle: only structural properties are checked
        sb_en = 1'b0;
        repeat (300) begin
            bus.IR = 16'($urandom);
            bus.AC = 16'($urandom);
            bus.DR = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            bus.E  = 1'($urandom);
            tick();
        end
        do_reset(2);

        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        n_errors++;
        $display("FAIL watchdog: time limit reached before end of test");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
